// File: rtl/apb_master_nslave.sv
// rtl/apb_master_nslave.sv - APB requester bridging a simple request port to N completers
//
// Purpose: turns a driver-side transfer request into an APB SETUP/ACCESS
// sequence toward one of NUM_SLAVES completers. The completer is chosen by
// the top SEL_W address bits. The bridge honours PREADY wait states and
// reports PSLVERR, decode errors and ACCESS timeouts through a one-cycle
// xfer_done/xfer_err pulse.
//
// Ports:
//   pclk, presetn        clock, asynchronous active-low reset
//   transfer             request strobe (taken in IDLE or on ACCESS completion)
//   read_write           1 = read, 0 = write
//   apb_write_paddr      write address
//   apb_write_data       write data
//   apb_read_paddr       read address
//   apb_read_data_out    last successfully read data
//   xfer_done/xfer_err   end-of-transfer pulse and its error flag
//   busy                 high while a transfer is in flight
//   psel..pwdata         APB requester outputs
//   prdata/pready/pslverr  flattened per-completer APB inputs
module apb_master_nslave #(
   parameter int AW         = 9,
   parameter int DW         = 8,
   parameter int NUM_SLAVES = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                     pclk,
   input  logic                     presetn,
   input  logic                     transfer,
   input  logic                     read_write,
   input  logic [AW-1:0]            apb_write_paddr,
   input  logic [DW-1:0]            apb_write_data,
   input  logic [AW-1:0]            apb_read_paddr,
   output logic [DW-1:0]            apb_read_data_out,
   output logic                     xfer_done,
   output logic                     xfer_err,
   output logic                     busy,
   output logic [NUM_SLAVES-1:0]    psel,
   output logic                     penable,
   output logic                     pwrite,
   output logic [AW-1:0]            paddr,
   output logic [DW-1:0]            pwdata,
   input  logic [NUM_SLAVES*DW-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]    pready,
   input  logic [NUM_SLAVES-1:0]    pslverr
);

   localparam int SEL_W = (NUM_SLAVES > 2) ? $clog2(NUM_SLAVES) : 1;
   // Counter only has to reach TIMEOUT-1: the abort fires on the cycle that
   // would make it TIMEOUT.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DERR
   } state_t;

   state_t                 state_q;
   logic [NUM_SLAVES-1:0]  psel_q;
   logic                   penable_q;
   logic                   pwrite_q;
   logic [AW-1:0]          paddr_q;
   logic [DW-1:0]          pwdata_q;
   logic [DW-1:0]          rdata_q;
   logic                   done_q;
   logic                   err_q;
   logic                   busy_q;
   logic [CW-1:0]          cnt_q;

   // Decode of the request currently presented on the driver side
   logic [AW-1:0]          req_addr_d;
   logic [SEL_W-1:0]       req_idx_d;
   logic                   req_ok_d;
   logic [NUM_SLAVES-1:0]  req_sel_d;
   logic                   take_req;

   // Response of the selected completer; psel_q is the mask, so replies from
   // unselected completers never leak in.
   logic                   sel_ready;
   logic                   sel_err;
   logic [DW-1:0]          sel_rdata;

   always_comb begin
      req_addr_d = read_write ? apb_read_paddr : apb_write_paddr;
      req_idx_d  = req_addr_d[AW-1 -: SEL_W];
      req_ok_d   = (32'(req_idx_d) < NUM_SLAVES);
      req_sel_d  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         req_sel_d[i] = (32'(req_idx_d) == 32'(i));
      end
   end

   always_comb begin
      sel_ready = |(pready & psel_q);
      sel_err   = |(pslverr & psel_q);
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (psel_q[i]) begin
            sel_rdata = sel_rdata | prdata[i*DW +: DW];
         end
      end
   end

   assign take_req = transfer &&
                     ((state_q == S_IDLE) || ((state_q == S_ACCESS) && sel_ready));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
            end

            S_SETUP: begin
               penable_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= S_ACCESS;
            end

            S_ACCESS: begin
               if (sel_ready) begin
                  done_q <= 1'b1;
                  err_q  <= sel_err;
                  if (!pwrite_q && !sel_err) begin
                     rdata_q <= sel_rdata;
                  end
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                  done_q    <= 1'b1;
                  err_q     <= 1'b1;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_DERR: begin
               // Entered back-to-back from a completing ACCESS, the previous
               // done pulse is still showing; hold one extra cycle so the two
               // pulses stay separate.
               if (!done_q) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase

         // A new request overrides the return-to-IDLE of a completing ACCESS,
         // giving SETUP directly with penable low for that cycle.
         if (take_req) begin
            pwrite_q  <= ~read_write;
            paddr_q   <= req_addr_d;
            pwdata_q  <= apb_write_data;
            psel_q    <= req_sel_d;
            penable_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= req_ok_d ? S_SETUP : S_DERR;
         end
      end
   end

   assign psel              = psel_q;
   assign penable           = penable_q;
   assign pwrite            = pwrite_q;
   assign paddr             = paddr_q;
   assign pwdata            = pwdata_q;
   assign apb_read_data_out = rdata_q;
   assign xfer_done         = done_q;
   assign xfer_err          = err_q;
   assign busy              = busy_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// tb/tb_apb_master_nslave.sv - self-checking bench for apb_master_nslave
module tb_apb_master_nslave;

   localparam int AW = 9;
   localparam int DW = 8;
   localparam int NS = 3;
   localparam int TO = 4;

   logic             pclk = 1'b0;
   logic             presetn = 1'b0;
   logic             transfer = 1'b0;
   logic             read_write = 1'b0;
   logic [AW-1:0]    apb_write_paddr = '0;
   logic [DW-1:0]    apb_write_data = '0;
   logic [AW-1:0]    apb_read_paddr = '0;
   logic [DW-1:0]    apb_read_data_out;
   logic             xfer_done;
   logic             xfer_err;
   logic             busy;
   logic [NS-1:0]    psel;
   logic             penable;
   logic             pwrite;
   logic [AW-1:0]    paddr;
   logic [DW-1:0]    pwdata;
   logic [NS*DW-1:0] prdata = '0;
   logic [NS-1:0]    pready = '0;
   logic [NS-1:0]    pslverr = '0;

   int               n_checks = 0;
   int               n_fail = 0;
   int               wait_cfg = 0;
   logic             err_cfg = 1'b0;
   logic [7:0]       model_rdata = 8'h00;

   apb_master_nslave #(
      .AW(AW), .DW(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)
   ) dut (
      .pclk(pclk), .presetn(presetn), .transfer(transfer), .read_write(read_write),
      .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
      .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
      .xfer_done(xfer_done), .xfer_err(xfer_err), .busy(busy),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Completer model: the selected completer raises pready after wait_cfg
   // ACCESS cycles; unselected completers and idle cycles carry random noise.
   initial begin
      int acc_n;
      logic [31:0] r;
      acc_n = 0;
      forever begin
         @(negedge pclk);
         r = $urandom;
         if (penable) begin
            for (int i = 0; i < NS; i++) begin
               pready[i]  = psel[i] ? (acc_n >= wait_cfg) : r[i];
               pslverr[i] = psel[i] ? err_cfg : r[i+8];
            end
            acc_n++;
         end else begin
            acc_n   = 0;
            pready  = r[NS-1:0];
            pslverr = r[NS+7:8];
         end
      end
   end

   typedef struct {
      logic       rw;
      logic [8:0] addr;
      logic [7:0] wd;
      int         wt;
      logic       se;
      logic [7:0] rd;
      logic       exp_err;
      int         exp_lat;
      int         exp_pc;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs[8];

   // Drives one request at a negedge and follows it to its done pulse.
   // exp_lat counts negedges after the accepting posedge; exp_pc counts
   // cycles with psel asserted.
   task automatic do_xfer(input string tag, input logic rw, input logic [8:0] addr,
                          input logic [7:0] wd, input int wt, input logic se,
                          input logic [7:0] rd, input logic exp_err, input int exp_lat,
                          input int exp_pc, input logic [7:0] exp_rd);
      int         idx;
      int         lat;
      int         pc;
      int         psel_bad;
      logic [31:0] r;
      logic [2:0] exp_sel;
      logic       got_err;
      logic       busy_at_done;
      logic       setup_seen;
      logic [8:0] s_paddr;
      logic       s_pwrite;
      logic [7:0] s_pwdata;
      idx = int'(addr[8:7]);
      exp_sel = 3'b000;
      if (idx < NS) exp_sel = 3'b001 << idx;
      r = $urandom;
      prdata = r[23:0];
      if (idx < NS) prdata[idx*8 +: 8] = rd;
      wait_cfg = wt;
      err_cfg = se;
      r = $urandom;
      transfer = 1'b1;
      read_write = rw;
      apb_write_data = wd;
      if (rw) begin
         apb_read_paddr = addr;
         apb_write_paddr = r[8:0];
      end else begin
         apb_write_paddr = addr;
         apb_read_paddr = r[8:0];
      end
      @(posedge pclk);
      lat = 0; pc = 0; psel_bad = 0; got_err = 1'b0; busy_at_done = 1'b1;
      setup_seen = 1'b0; s_paddr = '0; s_pwrite = 1'b0; s_pwdata = '0;
      for (int j = 1; j <= 40 && lat == 0; j++) begin
         @(negedge pclk);
         if (j == 1) begin
            r = $urandom;
            transfer = 1'b0;
            read_write = r[20];
            apb_write_paddr = r[8:0];
            apb_read_paddr = r[17:9];
            apb_write_data = r[31:24];
         end
         if (psel != '0) begin
            pc++;
            if (psel != exp_sel) psel_bad++;
            if (!penable && !setup_seen) begin
               setup_seen = 1'b1;
               s_paddr = paddr;
               s_pwrite = pwrite;
               s_pwdata = pwdata;
            end
         end
         if (xfer_done) begin
            lat = j;
            got_err = xfer_err;
            busy_at_done = busy;
         end
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_err"}, 64'(got_err), 64'(exp_err));
      chk({tag, "_psel_cycles"}, 64'(pc), 64'(exp_pc));
      chk({tag, "_rdata"}, 64'(apb_read_data_out), 64'(exp_rd));
      chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
      if (exp_pc > 0) begin
         chk({tag, "_setup"}, {setup_seen, s_paddr, s_pwrite, s_pwdata},
             {1'b1, addr, ~rw, wd});
         chk({tag, "_psel_value"}, 64'(psel_bad), 64'd0);
      end
      @(negedge pclk);
      chk({tag, "_done_pulse"}, 64'(xfer_done), 64'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic        rw;
      logic [8:0]  addr;
      logic [7:0]  wd;
      logic [7:0]  rd;
      int          wt;
      logic        se;
      int          idx;
      logic        e_err;
      int          e_lat;
      int          e_pc;
      int          done_cnt;

      //          rw    addr    wd     wt se    rd     err   lat pc rdata
      vecs[0] = '{1'b0, 9'h010, 8'hA5, 0, 1'b0, 8'h00, 1'b0, 3, 2, 8'h00};
      vecs[1] = '{1'b1, 9'h105, 8'h11, 3, 1'b0, 8'h3C, 1'b0, 6, 5, 8'h3C};
      vecs[2] = '{1'b1, 9'h1C0, 8'h22, 0, 1'b0, 8'hEE, 1'b1, 2, 0, 8'h3C};
      vecs[3] = '{1'b1, 9'h0A0, 8'h33, 4, 1'b0, 8'hD2, 1'b1, 6, 5, 8'h3C};
      vecs[4] = '{1'b1, 9'h0A0, 8'h44, 1, 1'b1, 8'h77, 1'b1, 4, 3, 8'h3C};
      vecs[5] = '{1'b1, 9'h081, 8'h55, 0, 1'b0, 8'h5A, 1'b0, 3, 2, 8'h5A};
      vecs[6] = '{1'b0, 9'h1FF, 8'h66, 0, 1'b0, 8'h00, 1'b1, 2, 0, 8'h5A};
      vecs[7] = '{1'b0, 9'h17E, 8'h0F, 2, 1'b1, 8'h00, 1'b1, 5, 4, 8'h5A};

      repeat (3) @(negedge pclk);
      chk("reset_outputs_held", {psel, penable, pwrite, paddr, pwdata, apb_read_data_out,
          xfer_done, xfer_err, busy}, 64'd0);
      presetn = 1'b1;
      @(negedge pclk);
      chk("reset_outputs_idle", {psel, penable, pwrite, paddr, pwdata, apb_read_data_out,
          xfer_done, xfer_err, busy}, 64'd0);

      for (int i = 0; i < 8; i++) begin
         do_xfer($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wd, vecs[i].wt,
                 vecs[i].se, vecs[i].rd, vecs[i].exp_err, vecs[i].exp_lat,
                 vecs[i].exp_pc, vecs[i].exp_rd);
         model_rdata = vecs[i].exp_rd;
      end

      // Back-to-back: write to completer 0, then read from completer 1 with
      // transfer held high across the write's completion.
      wait_cfg = 0;
      err_cfg = 1'b0;
      r = $urandom;
      prdata = r[23:0];
      prdata[15:8] = 8'hC3;
      transfer = 1'b1;
      read_write = 1'b0;
      apb_write_paddr = 9'h020;
      apb_write_data = 8'h5E;
      apb_read_paddr = 9'h1C0;
      @(posedge pclk);
      @(negedge pclk);
      chk("b2b_setup1", {psel, penable, pwrite}, {3'b001, 1'b0, 1'b1});
      read_write = 1'b1;
      apb_read_paddr = 9'h090;
      @(negedge pclk);
      chk("b2b_access1", {psel, penable, xfer_done}, {3'b001, 1'b1, 1'b0});
      @(negedge pclk);
      chk("b2b_setup2", {psel, penable, pwrite, paddr, xfer_done, xfer_err, busy},
          {3'b010, 1'b0, 1'b0, 9'h090, 1'b1, 1'b0, 1'b1});
      transfer = 1'b0;
      @(negedge pclk);
      chk("b2b_access2", {psel, penable, xfer_done}, {3'b010, 1'b1, 1'b0});
      @(negedge pclk);
      chk("b2b_done2", {psel, penable, xfer_done, xfer_err, apb_read_data_out},
          {3'b000, 1'b0, 1'b1, 1'b0, 8'hC3});
      model_rdata = 8'hC3;
      @(negedge pclk);

      // Randomized transfers against a transaction-level model.
      for (int k = 0; k < 50; k++) begin
         r = $urandom;
         rw = r[0];
         addr = r[9:1];
         wd = r[17:10];
         rd = r[25:18];
         se = r[26];
         wt = $urandom_range(0, 5);
         idx = int'(addr[8:7]);
         if (idx >= NS) begin
            e_err = 1'b1; e_lat = 2; e_pc = 0;
         end else if (wt >= TO) begin
            e_err = 1'b1; e_lat = TO + 2; e_pc = TO + 1;
         end else begin
            e_err = se; e_lat = wt + 3; e_pc = wt + 2;
            if (rw && !se) model_rdata = rd;
         end
         do_xfer($sformatf("rnd%0d", k), rw, addr, wd, wt, se, rd, e_err, e_lat, e_pc,
                 model_rdata);
      end

      // Reset during ACCESS: everything clears at once and no done pulse follows.
      wait_cfg = 5;
      err_cfg = 1'b0;
      transfer = 1'b1;
      read_write = 1'b1;
      apb_read_paddr = 9'h044;
      @(posedge pclk);
      @(negedge pclk);
      transfer = 1'b0;
      @(negedge pclk);
      chk("midreset_in_access", {psel, penable}, {3'b001, 1'b1});
      #2 presetn = 1'b0;
      #1 chk("midreset_outputs", {psel, penable, pwrite, paddr, pwdata, apb_read_data_out,
             xfer_done, xfer_err, busy}, 64'd0);
      done_cnt = 0;
      for (int j = 0; j < 3; j++) begin
         @(negedge pclk);
         if (xfer_done) done_cnt++;
      end
      presetn = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge pclk);
         if (xfer_done) done_cnt++;
      end
      chk("midreset_no_done", 64'(done_cnt), 64'd0);
      model_rdata = 8'h00;
      do_xfer("post_reset", 1'b1, 9'h0C4, 8'h00, 0, 1'b0, 8'h99, 1'b0, 3, 2, 8'h99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

endmodule
